// File: rtl/router_pkg.sv
// Shared router constants: default channel geometry, the position of the
// header tag bit and the LSB of the header length field. Used by the
// router FSM, the synchroniser and every output-channel FIFO.
package router_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // The packet length lives in the header word above the two address bits.
  localparam int LEN_LSB = 2;

  // The header tag is stored one bit above the data word.
  function automatic int tag_bit(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one router output channel. Each entry is a data word
// plus its header tag. The data read port is registered and has no reset.
// The tag and length field at the read address are also exposed without a
// register, so the owner can decode a header on the same edge that
// captures the word.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [DATA_W:0]             wr_word,
  input  logic                        rd_en,
  input  logic [$clog2(DEPTH)-1:0]    rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_tag,
  output logic [DATA_W-LEN_LSB-1:0]   rd_len
);

  localparam int TAG = tag_bit(DATA_W);

  logic [DATA_W:0] mem [DEPTH];

  // Store the tagged word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Capture the data part of the addressed entry on a read.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr][DATA_W-1:0];
  end

  assign rd_tag = mem[rd_addr][TAG];
  assign rd_len = mem[rd_addr][DATA_W-1:LEN_LSB];

endmodule

// File: rtl/router_fifo_param.sv
// Parametrised packet FIFO for one router output channel. Keeps the
// pointers, flags and the remaining-length counter of the packet being
// read; data lives in router_fifo_mem. Define ROUTER_FIFO_LEVEL_EN to get
// a registered occupancy output `level`.
module router_fifo_param
  import router_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_reset,
  input  logic                     w_en,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        d_in,
  input  logic                     r_en,
  output logic [DATA_W-1:0]        d_out,
  output logic                     empty,
  output logic                     full,
  output logic                     afull,
  output logic                     wr_err,
  output logic                     pkt_busy,
  output logic                     pkt_done
`ifdef ROUTER_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = DATA_W - LEN_LSB;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0]  CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_V = AFULL_TH[ADDR_W:0];

  logic [ADDR_W:0]     wr_ptr;
  logic [ADDR_W:0]     rd_ptr;
  logic [LEN_W:0]      cnt;
  logic                flush;
  logic                wr_acc;
  logic                rd_acc;
  logic                out_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_tag;
  logic [LEN_W-1:0]    rd_len;

  // Both resets flush the channel and mask any request on that edge.
  assign flush  = reset | soft_reset;

  // Flags come from the registered pointers, i.e. the state at cycle start.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_acc = w_en && !full && !flush;
  assign rd_acc = r_en && !empty && !flush;

  assign pkt_busy = (cnt != '0);

  // Memory contents survive a flush; they are unreachable once the
  // pointers are cleared, and d_out is forced to zero until the next read.
  assign d_out = out_valid ? rd_data : '0;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_word ({lfd_state, d_in}),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data),
    .rd_tag  (rd_tag),
    .rd_len  (rd_len)
  );

  // Advance the pointers on accepted transfers; wrap is natural modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Track whether d_out holds a word read since the last flush.
  always_ff @(posedge clk) begin
    if (flush)       out_valid <= 1'b0;
    else if (rd_acc) out_valid <= 1'b1;
  end

  // Flag a write that was turned away because the channel was full.
  always_ff @(posedge clk) begin
    if (flush) wr_err <= 1'b0;
    else       wr_err <= w_en && full;
  end

  // Load the packet length from a header, count down on payload reads and
  // pulse pkt_done on the read of the packet's last (parity) word.
  always_ff @(posedge clk) begin
    if (flush) begin
      cnt      <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (rd_acc) begin
        if (rd_tag) begin
          cnt <= {1'b0, rd_len} + CNT_ONE;
        end else if (cnt != '0) begin
          cnt      <= cnt - CNT_ONE;
          pkt_done <= (cnt == CNT_ONE);
        end
      end
    end
  end

`ifdef ROUTER_FIFO_LEVEL_EN
  // Keep a registered occupancy count alongside the pointers.
  always_ff @(posedge clk) begin
    if (flush) begin
      level <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  assign afull = (level >= AFULL_V);
`else
  logic [ADDR_W:0] occ;

  assign occ   = wr_ptr - rd_ptr;
  assign afull = (occ >= AFULL_V);
`endif

endmodule

// File: tb/tb_router_fifo_param.sv
// Self-checking bench for router_fifo_param. Instance u_dut uses the
// default 8-bit/16-deep geometry against a queue scoreboard; instance
// u_dut2 uses DATA_W=16, DEPTH=8, AFULL_TH=6 for the wide-header and
// almost-full threshold cases.
module tb_router_fifo_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        soft_reset, w_en, lfd_state, r_en;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        empty, full, afull, wr_err, pkt_busy, pkt_done;

  logic        soft_reset2, w_en2, lfd_state2, r_en2;
  logic [15:0] d_in2;
  logic [15:0] d_out2;
  logic        empty2, full2, afull2, wr_err2, pkt_busy2, pkt_done2;

`ifdef ROUTER_FIFO_LEVEL_EN
  logic [4:0]  level;
  logic [3:0]  level2;
`endif

  int assert_count = 0;
  int fail_count   = 0;

  // Scoreboard for u_dut: tagged words pushed on accepted writes.
  logic [8:0]  mq[$];
  logic [6:0]  m_cnt;
  logic [7:0]  exp_dout;
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  router_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(14)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .w_en       (w_en),
    .lfd_state  (lfd_state),
    .d_in       (d_in),
    .r_en       (r_en),
    .d_out      (d_out),
    .empty      (empty),
    .full       (full),
    .afull      (afull),
    .wr_err     (wr_err),
    .pkt_busy   (pkt_busy),
    .pkt_done   (pkt_done)
`ifdef ROUTER_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  router_fifo_param #(.DATA_W(16), .DEPTH(8), .AFULL_TH(6)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset2),
    .w_en       (w_en2),
    .lfd_state  (lfd_state2),
    .d_in       (d_in2),
    .r_en       (r_en2),
    .d_out      (d_out2),
    .empty      (empty2),
    .full       (full2),
    .afull      (afull2),
    .wr_err     (wr_err2),
    .pkt_busy   (pkt_busy2),
    .pkt_done   (pkt_done2)
`ifdef ROUTER_FIFO_LEVEL_EN
    ,
    .level      (level2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle on u_dut: predict from the scoreboard, drive, then compare.
  task automatic applyStimulus(input logic w, input logic lfd, input logic [7:0] d,
                               input logic r, input logic sr);
    logic [8:0] word;
    logic       was_full, was_empty, exp_err, exp_done;
    was_full  = (mq.size() == 16);
    was_empty = (mq.size() == 0);
    exp_err   = 1'b0;
    exp_done  = 1'b0;
    if (sr) begin
      mq.delete();
      m_cnt    = '0;
      exp_dout = '0;
    end else begin
      exp_err = w && was_full;
      if (r && !was_empty) begin
        word     = mq.pop_front();
        exp_dout = word[7:0];
        if (word[8]) begin
          m_cnt = {1'b0, word[7:2]} + 7'd1;
        end else if (m_cnt != 0) begin
          exp_done = (m_cnt == 7'd1);
          m_cnt    = m_cnt - 7'd1;
        end
      end
      if (w && !was_full) mq.push_back({lfd, d});
    end
    w_en = w; lfd_state = lfd; d_in = d; r_en = r; soft_reset = sr;
    @(posedge clk);
    #1;
    w_en = 1'b0; lfd_state = 1'b0; r_en = 1'b0; soft_reset = 1'b0;
    checkOutput("d_out",    32'(d_out),    32'(exp_dout));
    checkOutput("empty",    32'(empty),    32'(mq.size() == 0));
    checkOutput("full",     32'(full),     32'(mq.size() == 16));
    checkOutput("afull",    32'(afull),    32'(mq.size() >= 14));
    checkOutput("wr_err",   32'(wr_err),   32'(exp_err));
    checkOutput("pkt_done", 32'(pkt_done), 32'(exp_done));
    checkOutput("pkt_busy", 32'(pkt_busy), 32'(m_cnt != 0));
`ifdef ROUTER_FIFO_LEVEL_EN
    checkOutput("level",    32'(level),    32'(mq.size()));
`endif
  endtask

  // One cycle on u_dut2; checks are made by the caller.
  task automatic applyStimulus2(input logic w, input logic lfd, input logic [15:0] d, input logic r);
    w_en2 = w; lfd_state2 = lfd; d_in2 = d; r_en2 = r;
    @(posedge clk);
    #1;
    w_en2 = 1'b0; lfd_state2 = 1'b0; r_en2 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    soft_reset = 1'b0; w_en = 1'b0; lfd_state = 1'b0; d_in = '0; r_en = 1'b0;
    soft_reset2 = 1'b0; w_en2 = 1'b0; lfd_state2 = 1'b0; d_in2 = '0; r_en2 = 1'b0;
    m_cnt = '0;
    exp_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_d_out",    32'(d_out),    32'd0);
    checkOutput("rst_empty",    32'(empty),    32'd1);
    checkOutput("rst_full",     32'(full),     32'd0);
    checkOutput("rst_afull",    32'(afull),    32'd0);
    checkOutput("rst_wr_err",   32'(wr_err),   32'd0);
    checkOutput("rst_pkt_busy", 32'(pkt_busy), 32'd0);
    checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
    checkOutput("rst_empty2",   32'(empty2),   32'd1);
    reset = 1'b0;

    $display("[TB] fill to full, overflow write, drain");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] packet with header 0x14");
    applyStimulus(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h31 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] pointer wrap with simultaneous traffic");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] simultaneous read/write at full and at empty");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] soft_reset mid-packet, then a fresh packet");
    applyStimulus(1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h61 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] wide instance: almost-full threshold and long header");
    for (int k = 1; k <= 6; k++) begin
      applyStimulus2(1'b1, 1'b0, 16'(16'h1000 + k), 1'b0);
      q2.push_back(16'(16'h1000 + k));
      checkOutput("afull2", 32'(afull2), 32'(k >= 6));
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus2(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("d_out2_drain", 32'(d_out2), 32'(q2.pop_front()));
    end
    checkOutput("empty2_drained", 32'(empty2), 32'd1);
    applyStimulus2(1'b1, 1'b1, 16'd400, 1'b0);
    applyStimulus2(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("d_out2_hdr",    32'(d_out2),    32'd400);
    checkOutput("pkt_busy2_hdr", 32'(pkt_busy2), 32'd1);
    for (int i = 1; i <= 101; i++) begin
      applyStimulus2(1'b1, 1'b0, 16'(i), 1'b0);
      applyStimulus2(1'b0, 1'b0, 16'h0000, 1'b1);
      checkOutput("d_out2_pay",    32'(d_out2),    32'(i));
      checkOutput("pkt_done2",     32'(pkt_done2), 32'(i == 101));
      checkOutput("pkt_busy2",     32'(pkt_busy2), 32'(i != 101));
    end
    applyStimulus2(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("pkt_done2_pulse", 32'(pkt_done2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
